// File: rtl/vga_pkg.sv
// vga_pkg: shared widths, the pixel-stream payload struct and the overlay colours
// used by the vga_if pipeline stages.
package vga_pkg;

  localparam int unsigned HC_W  = 11;  // hcount width
  localparam int unsigned VC_W  = 11;  // vcount width
  localparam int unsigned RGB_W = 12;  // 4:4:4 colour
  localparam int unsigned GEO_W = 12;  // signed window-relative coordinates

  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t C_TRACE  = 12'hAA0;
  localparam rgb_t C_BORDER = 12'hFA0;
  localparam rgb_t C_GRID   = 12'h444;

  // One pixel of the timing stream, used for the pipeline delay registers.
  typedef struct packed {
    logic [HC_W-1:0] hcount;
    logic [VC_W-1:0] vcount;
    logic            hsync;
    logic            vsync;
    logic            hblnk;
    logic            vblnk;
    rgb_t            rgb;
  } vga_t;

endpackage

// File: rtl/vga_if.sv
// vga_if: pixel timing + colour bundle passed between video pipeline stages.
//   modport in  : stage consumes the stream
//   modport out : stage produces the stream
interface vga_if;
  import vga_pkg::*;

  logic [HC_W-1:0] hcount;
  logic [VC_W-1:0] vcount;
  logic            hsync;
  logic            vsync;
  logic            hblnk;
  logic            vblnk;
  rgb_t            rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_trace_buffer.sv
// trace_buffer: ping-pong sample RAM (2*N_SAMPLES x DATA_W, 1-cycle read).
//   wr_valid/wr_data/wr_ready : capture port into the back bank
//   rd_addr -> rd_data        : front-bank read, data one cycle later
//   swap_req -> swap_c        : vblank edge request / swap taken this cycle
//   front_valid               : front bank holds a complete record
module trace_buffer
  import vga_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 256,
  parameter int unsigned DATA_W    = 8,
  localparam int unsigned AW       = $clog2(N_SAMPLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              swap_req,
  output logic              swap_c,
  output logic              front_valid
);

  logic [DATA_W-1:0] mem [2*N_SAMPLES];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              back_full_q, back_full_d;
  logic              bank_q, bank_d;
  logic              front_valid_q, front_valid_d;
  logic              wr_ready_q, wr_ready_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_en_c;
  logic              last_c;

  // Capture, full flag and swap decision; a record finishing on the edge cycle still swaps.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    back_full_d   = back_full_q;
    bank_d        = bank_q;
    front_valid_d = front_valid_q;
    wr_en_c       = wr_valid && wr_ready_q;
    last_c        = wr_en_c && (wr_ptr_q == AW'(N_SAMPLES - 1));
    swap_c        = swap_req && (back_full_q || last_c);
    rd_data_d     = mem[{bank_q, rd_addr}];
    if (wr_en_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (last_c) back_full_d = 1'b1;
    end
    if (swap_c) begin
      bank_d        = ~bank_q;
      wr_ptr_d      = '0;
      back_full_d   = 1'b0;
      front_valid_d = 1'b1;
    end
    wr_ready_d = ~back_full_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      back_full_q   <= 1'b0;
      bank_q        <= 1'b0;
      front_valid_q <= 1'b0;
      wr_ready_q    <= 1'b1;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      back_full_q   <= back_full_d;
      bank_q        <= bank_d;
      front_valid_q <= front_valid_d;
      wr_ready_q    <= wr_ready_d;
    end
  end

  // RAM array and read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[{~bank_q, wr_ptr_q}] <= wr_data;
    rd_data_q <= rd_data_d;
  end

  assign wr_ready    = wr_ready_q;
  assign rd_data     = rd_data_q;
  assign front_valid = front_valid_q;

endmodule

// File: rtl/draw_trace.sv
// draw_trace: oscilloscope overlay (border, grid, dot/line trace) on a vga_if stream.
//   sample_valid/sample_data/sample_ready : record capture
//   line_mode/grid_en                     : display options, latched at buffer swap
//   frame_swapped                         : one-cycle pulse after a swap
//   in/out                                : pixel stream, out delayed 2 cycles
module draw_trace
  import vga_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 256,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned X0        = 128,
  parameter int unsigned Y0        = 500,
  parameter int unsigned GRID_STEP = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              sample_ready,
  input  logic              line_mode,
  input  logic              grid_en,
  output logic              frame_swapped,
  vga_if.in                 in,
  vga_if.out                out
);

  localparam int unsigned AW   = $clog2(N_SAMPLES);
  localparam int unsigned GS_W = $clog2(GRID_STEP);
  localparam logic signed [GEO_W-1:0] N_S = GEO_W'(N_SAMPLES);
  localparam logic signed [GEO_W-1:0] H_S = GEO_W'(2**DATA_W);
  localparam logic signed [GEO_W-1:0] M1  = '1;

  vga_t                     pix1_q, pix1_d, out_q, out_d;
  logic signed [GEO_W-1:0]  c_q, c_d, r_q, r_d;
  logic                     vblnk_prev_q, vblnk_prev_d;
  logic [DATA_W-1:0]        prev_q, prev_d;
  logic                     line_mode_q, line_mode_d;
  logic                     grid_en_q, grid_en_d;
  logic                     frame_swapped_q, frame_swapped_d;

  logic [AW-1:0]            rd_addr_c;
  logic [DATA_W-1:0]        rd_data;
  logic                     swap_req_c, swap_c, front_valid;

  logic [DATA_W-1:0]        s_left_c, lo_c, hi_c, rv_c;
  logic                     in_win_c, border_c, grid_c, trace_c;

  trace_buffer #(.N_SAMPLES(N_SAMPLES), .DATA_W(DATA_W)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (sample_valid),
    .wr_data     (sample_data),
    .wr_ready    (sample_ready),
    .rd_addr     (rd_addr_c),
    .rd_data     (rd_data),
    .swap_req    (swap_req_c),
    .swap_c      (swap_c),
    .front_valid (front_valid)
  );

  // Stage 1: window coordinates, RAM read issue, vblank edge detect, option latch.
  always_comb begin
    pix1_d.hcount = in.hcount;
    pix1_d.vcount = in.vcount;
    pix1_d.hsync  = in.hsync;
    pix1_d.vsync  = in.vsync;
    pix1_d.hblnk  = in.hblnk;
    pix1_d.vblnk  = in.vblnk;
    pix1_d.rgb    = in.rgb;
    c_d           = GEO_W'(in.hcount) - GEO_W'(X0);
    r_d           = GEO_W'(Y0) - GEO_W'(in.vcount);
    rd_addr_c     = c_d[AW-1:0];
    vblnk_prev_d  = in.vblnk;
    swap_req_c    = in.vblnk && !vblnk_prev_q;
    line_mode_d   = line_mode_q;
    grid_en_d     = grid_en_q;
    if (swap_c) begin
      line_mode_d = line_mode;
      grid_en_d   = grid_en;
    end
    frame_swapped_d = swap_c;
  end

  // Stage 2: compare against s[c] and the held s[c-1], then priority select.
  always_comb begin
    prev_d   = rd_data;
    s_left_c = (c_q == '0) ? rd_data : prev_q;
    lo_c     = (s_left_c < rd_data) ? s_left_c : rd_data;
    hi_c     = (s_left_c < rd_data) ? rd_data : s_left_c;
    rv_c     = r_q[DATA_W-1:0];
    in_win_c = !c_q[GEO_W-1] && (c_q < N_S) && !r_q[GEO_W-1] && (r_q < H_S);
    border_c = ((c_q == M1 || c_q == N_S) && r_q >= M1 && r_q <= H_S) ||
               ((r_q == M1 || r_q == H_S) && c_q >= M1 && c_q <= N_S);
    grid_c   = in_win_c && grid_en_q &&
               (c_q[GS_W-1:0] == '0 || r_q[GS_W-1:0] == '0);
    trace_c  = in_win_c && front_valid &&
               (line_mode_q ? (rv_c >= lo_c && rv_c <= hi_c) : (rv_c == rd_data));
    out_d = pix1_q;
    if (!pix1_q.hblnk && !pix1_q.vblnk) begin
      if (trace_c)       out_d.rgb = C_TRACE;
      else if (border_c) out_d.rgb = C_BORDER;
      else if (grid_c)   out_d.rgb = C_GRID;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix1_q          <= '0;
      out_q           <= '0;
      c_q             <= '0;
      r_q             <= '0;
      vblnk_prev_q    <= 1'b0;
      prev_q          <= '0;
      line_mode_q     <= 1'b0;
      grid_en_q       <= 1'b1;
      frame_swapped_q <= 1'b0;
    end else begin
      pix1_q          <= pix1_d;
      out_q           <= out_d;
      c_q             <= c_d;
      r_q             <= r_d;
      vblnk_prev_q    <= vblnk_prev_d;
      prev_q          <= prev_d;
      line_mode_q     <= line_mode_d;
      grid_en_q       <= grid_en_d;
      frame_swapped_q <= frame_swapped_d;
    end
  end

  assign out.hcount    = out_q.hcount;
  assign out.vcount    = out_q.vcount;
  assign out.hsync     = out_q.hsync;
  assign out.vsync     = out_q.vsync;
  assign out.hblnk     = out_q.hblnk;
  assign out.vblnk     = out_q.vblnk;
  assign out.rgb       = out_q.rgb;
  assign frame_swapped = frame_swapped_q;

endmodule

// File: tb/tb_draw_trace.sv
// Directed bench for draw_trace with hand-computed expected colours.
module tb_draw_trace;
  import vga_pkg::*;

  localparam int N  = 256;
  localparam int DW = 8;
  localparam int X0 = 128;
  localparam int Y0 = 500;
  localparam int GS = 32;
  localparam rgb_t BG = 12'h123;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_valid;
  logic [DW-1:0] sample_data;
  logic          sample_ready;
  logic          line_mode;
  logic          grid_en;
  logic          frame_swapped;

  vga_if vin ();
  vga_if vout ();

  draw_trace #(.N_SAMPLES(N), .DATA_W(DW), .X0(X0), .Y0(Y0), .GRID_STEP(GS)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .sample_ready  (sample_ready),
    .line_mode     (line_mode),
    .grid_en       (grid_en),
    .frame_swapped (frame_swapped),
    .in            (vin),
    .out           (vout)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  rgb_t got_rgb [64];
  logic [HC_W-1:0] got_h [64];
  logic fs1, fs2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_pix(input int h, input int v, input logic hb, input logic vb, input rgb_t c);
    vin.hcount = HC_W'(h);
    vin.vcount = VC_W'(v);
    vin.hsync  = hb;
    vin.vsync  = vb;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = c;
  endtask

  // Streams n consecutive pixels of one row; got_rgb[k] is the output for hcount h0+k.
  task automatic scan(input int v, input int h0, input int n);
    for (int k = 0; k <= n; k++) begin
      set_pix(h0 + k, v, 1'b0, 1'b0, BG);
      @(posedge clk); #1;
      if (k >= 1) begin
        got_rgb[k-1] = vout.rgb;
        got_h[k-1]   = vout.hcount;
      end
    end
  endtask

  // Column c of a scan started at X0-2.
  function automatic rgb_t at(input int c);
    return got_rgb[c + 2];
  endfunction

  task automatic vblank();
    set_pix(0, 768, 1'b1, 1'b1, 12'h000);
    @(posedge clk); #1;
    fs1 = frame_swapped;
    @(posedge clk); #1;
    fs2 = frame_swapped;
    set_pix(0, 0, 1'b1, 1'b0, 12'h000);
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] sval(input int mode, input int i);
    case (mode)
      1:       return (i == 4) ? DW'(10) : (i == 5) ? DW'(50) : DW'(i);
      2:       return (i < 256) ? DW'(255 - i) : DW'(200);
      default: return DW'(i);
    endcase
  endfunction

  task automatic write_range(input int i0, input int i1, input int mode);
    for (int i = i0; i < i1; i++) begin
      sample_valid = 1'b1;
      sample_data  = sval(mode, i);
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    line_mode    = 1'b0;
    grid_en      = 1'b1;
    set_pix(X0 + 5, Y0 - 5, 1'b0, 1'b0, 12'hFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rgb", 32'(vout.rgb), 32'h0);
    chk("reset_hcount", 32'(vout.hcount), 32'h0);
    chk("reset_ready", 32'(sample_ready), 32'h1);
    chk("reset_swapped", 32'(frame_swapped), 32'h0);
    rst = 1'b0;

    // Empty buffer: border and grid only, 2-cycle latency.
    scan(Y0 - 10, X0 - 2, 40);
    chk("latency_hcount", 32'(got_h[0]), 32'(X0 - 2));
    chk("empty_outside", 32'(at(-2)), 32'(BG));
    chk("empty_border_left", 32'(at(-1)), 32'(C_BORDER));
    chk("empty_grid_c0", 32'(at(0)), 32'(C_GRID));
    chk("empty_plain_c10", 32'(at(10)), 32'(BG));
    chk("empty_grid_c32", 32'(at(32)), 32'(C_GRID));
    scan(Y0 + 1, X0 - 2, 8);
    chk("border_bottom_outside", 32'(at(-2)), 32'(BG));
    chk("border_bottom_corner", 32'(at(-1)), 32'(C_BORDER));
    chk("border_bottom_c5", 32'(at(5)), 32'(C_BORDER));
    scan(Y0, X0 - 2, 8);
    chk("grid_row0_c5", 32'(at(5)), 32'(C_GRID));
    scan(Y0 - 256, X0 - 2, 8);
    chk("border_top_c5", 32'(at(5)), 32'(C_BORDER));
    scan(Y0 - 10, X0 + N - 2, 4);
    chk("right_c255", 32'(got_rgb[1]), 32'(BG));
    chk("right_border_c256", 32'(got_rgb[2]), 32'(C_BORDER));
    chk("right_outside_c257", 32'(got_rgb[3]), 32'(BG));
    set_pix(X0 - 1, Y0 - 10, 1'b1, 1'b0, 12'h5A5);
    @(posedge clk); @(posedge clk); #1;
    chk("hblank_passthrough", 32'(vout.rgb), 32'h5A5);
    vblank();
    chk("no_swap_when_empty", 32'(fs1), 32'h0);
    chk("sample_ready_idle", 32'(sample_ready), 32'h1);

    // Ramp record, dots mode, grid disabled at swap.
    grid_en = 1'b0;
    write_range(0, 255, 0);
    chk("ready_before_last", 32'(sample_ready), 32'h1);
    write_range(255, 256, 0);
    chk("ready_after_full", 32'(sample_ready), 32'h0);
    vblank();
    grid_en = 1'b1;
    chk("ramp_swap_pulse", 32'(fs1), 32'h1);
    chk("ramp_swap_pulse_end", 32'(fs2), 32'h0);
    chk("ready_after_swap", 32'(sample_ready), 32'h1);
    scan(Y0 - 10, X0 - 2, 16);
    chk("dot_c10_r10", 32'(at(10)), 32'(C_TRACE));
    chk("dot_c9_r10", 32'(at(9)), 32'(BG));
    chk("grid_latched_off", 32'(at(0)), 32'(BG));
    chk("dot_border_left", 32'(at(-1)), 32'(C_BORDER));
    scan(Y0 - 11, X0 - 2, 16);
    chk("dot_c10_r11", 32'(at(10)), 32'(BG));
    chk("dot_c11_r11", 32'(at(11)), 32'(C_TRACE));

    // Line mode, s[4]=10, s[5]=50.
    line_mode = 1'b1;
    write_range(0, 256, 1);
    vblank();
    line_mode = 1'b0;
    chk("line_swap_pulse", 32'(fs1), 32'h1);
    scan(Y0 - 9, X0 - 2, 10);
    chk("line_c5_r9", 32'(at(5)), 32'(BG));
    scan(Y0 - 10, X0 - 2, 10);
    chk("line_c5_r10", 32'(at(5)), 32'(C_TRACE));
    chk("line_c0_r10_grid", 32'(at(0)), 32'(C_GRID));
    scan(Y0 - 30, X0 - 2, 10);
    chk("line_c5_r30", 32'(at(5)), 32'(C_TRACE));
    scan(Y0 - 50, X0 - 2, 10);
    chk("line_c5_r50", 32'(at(5)), 32'(C_TRACE));
    scan(Y0 - 51, X0 - 2, 10);
    chk("line_c5_r51", 32'(at(5)), 32'(BG));
    scan(Y0, X0 - 2, 10);
    chk("line_c0_r0", 32'(at(0)), 32'(C_TRACE));
    scan(Y0 - 1, X0 - 2, 10);
    chk("line_c0_r1", 32'(at(0)), 32'(C_GRID));

    // Record completed only every other frame.
    write_range(0, 128, 0);
    vblank();
    chk("half_no_swap", 32'(fs1), 32'h0);
    scan(Y0 - 30, X0 - 2, 10);
    chk("front_unchanged", 32'(at(5)), 32'(C_TRACE));
    write_range(128, 256, 0);
    vblank();
    chk("alt_frame_swap", 32'(fs1), 32'h1);
    scan(Y0 - 30, X0 - 2, 10);
    chk("alt_dots_c5_r30", 32'(at(5)), 32'(BG));
    scan(Y0 - 5, X0 - 2, 10);
    chk("alt_dots_c5_r5", 32'(at(5)), 32'(C_TRACE));

    // 300 samples offered: 256..299 dropped.
    write_range(0, 256, 2);
    chk("ready_low_at_256", 32'(sample_ready), 32'h0);
    write_range(256, 300, 2);
    chk("ready_low_at_300", 32'(sample_ready), 32'h0);
    vblank();
    chk("over_swap", 32'(fs1), 32'h1);
    scan(Y0 - 235, X0 - 2, 24);
    chk("over_c20_r235", 32'(at(20)), 32'(C_TRACE));
    scan(Y0 - 200, X0 - 2, 24);
    chk("over_c20_r200", 32'(at(20)), 32'(BG));

    // Reset mid-capture with the back bank half full.
    write_range(0, 128, 0);
    set_pix(X0 + 5, Y0 - 5, 1'b0, 1'b0, BG);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_rgb", 32'(vout.rgb), 32'h0);
    chk("midrst_ready", 32'(sample_ready), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    scan(Y0 - 5, X0 - 2, 10);
    chk("midrst_no_trace", 32'(at(5)), 32'(BG));
    chk("midrst_grid_on", 32'(at(0)), 32'(C_GRID));
    write_range(0, 128, 0);
    vblank();
    chk("midrst_partial_discarded", 32'(fs1), 32'h0);
    write_range(128, 256, 0);
    vblank();
    chk("midrst_full_swap", 32'(fs1), 32'h1);
    scan(Y0 - 5, X0 - 2, 10);
    chk("midrst_trace_back", 32'(at(5)), 32'(C_TRACE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_trace.md
# draw_trace

Parametrised oscilloscope trace renderer inserted in the vga_if pipeline after the background stage. It captures a record of N_SAMPLES samples into a ping-pong buffer, swaps buffers only during vertical blanking so a frame never tears, and overlays border, grid and trace (dots or connected vertical-line segments) on the incoming pixel stream. It supersedes the fixed 256x8-bit, combinational-array display drawer.

## Interface
- N_SAMPLES, 256, trace width in pixels and record length; power of 2, 16..1024
- DATA_W, 8, sample width; window height H = 2**DATA_W rows
- X0, 128, screen column of sample 0
- Y0, 500, screen row of sample value 0 (bottom of window)
- GRID_STEP, 32, grid pitch in pixels; power of 2
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- sample_valid  in  1  sample_data is valid this cycle
- sample_data  in  DATA_W  unsigned sample
- sample_ready  out  1  back buffer can accept a sample
- line_mode  in  1  0 = dots, 1 = connected segments; sampled once per frame at swap
- grid_en  in  1  grid overlay enable; sampled once per frame at swap
- frame_swapped  out  1  one-cycle pulse when buffers swap
- in  vga_if.in  —  upstream timing and rgb
- out  vga_if.out  —  delayed timing and overlaid rgb

## Operation
- Capture: a write occurs when sample_valid && sample_ready, storing the sample at wr_ptr in the back bank. wr_ptr then increments. A write at N_SAMPLES-1 sets back_full, and sample_ready drops the next cycle. Samples offered while sample_ready is low are dropped, not queued.
- Swap: a swap occurs on the 0->1 edge of in.vblnk when back_full = 1, or when back_full is set in that same cycle. On swap:
  - front/back banks toggle;
  - wr_ptr = 0 and back_full = 0;
  - front_valid = 1;
  - line_mode and grid_en are latched;
  - frame_swapped pulses for one cycle.
- If back_full = 0 at the vblnk edge, no swap occurs and the old front keeps displaying.
- Geometry: column c = hcount - X0 and row r = Y0 - vcount. Both use 12-bit signed arithmetic, so there is no unsigned wrap. The window is 0<=c<N_SAMPLES and 0<=r<H.
- Border: lit where c = -1 or c = N_SAMPLES, with -1<=r<=H. Also lit where r = -1 or r = H, with -1<=c<=N_SAMPLES.
- Grid: lit inside the window where c mod GRID_STEP = 0 or r mod GRID_STEP = 0, and only when grid_en was latched as 1.
- Trace, valid only when front_valid = 1:
  - dots mode: lit when r = s[c];
  - line mode: lit when min(s[c-1], s[c]) <= r <= max(s[c-1], s[c]);
  - at c = 0, s[-1] is taken as s[0].
  - s[c-1] is the previous-column read held in a register, so there is exactly one RAM read per pixel.
- Priority: trace (C_TRACE) > border (C_BORDER) > grid (C_GRID) > in.rgb.
- Blanking: no overlay is applied while hblnk or vblnk is set; rgb passes through unchanged.

## Timing
- Pixel path latency is exactly 2 cycles. Stage 1 issues the RAM read and computes c/r; stage 2 compares and selects rgb. All vga_if fields are delayed by 2 cycles together.
- The RAM read is synchronous (1 cycle), so it is inferable as block RAM of 2*N_SAMPLES x DATA_W.
- Reset values:
  - all out.* = 0 and frame_swapped = 0;
  - sample_ready = 1, wr_ptr = 0, back_full = 0, front_valid = 0;
  - active bank = 0, latched line_mode = 0, latched grid_en = 1.
- RAM contents are not reset; front_valid gates the trace until the first swap.
- If reset asserts mid-capture or mid-frame, all state returns immediately to the reset values, and the partial record is discarded.
- A write and a swap in the same cycle: the write lands in the old back bank, which becomes the new front.

## Structure
- vga_pkg gains C_TRACE (12'hAA0), C_BORDER (12'hFA0) and C_GRID (12'h444) as 12-bit rgb constants.
- Sub-module trace_buffer holds the ping-pong RAM, wr_ptr, back_full, bank select and swap logic. It has a write port, a read port (addr to data, 1 cycle) and a swap_req/swapped interface.
- draw_trace contains the coordinate pipeline, the compare/priority logic and the trace_buffer instance.

## Test plan
- Reset with 1024x768 timing and no samples: the full frame shows border and grid only, out delayed by 2 cycles vs in, and sample_ready = 1.
- Write a ramp s[i] = i for N=256 before vblnk: frame_swapped pulses once at the vblnk edge. The next frame shows a diagonal, with pixel (X0+10, Y0-10) = C_TRACE and (X0+10, Y0-11) ≠ C_TRACE in dots mode.
- Line mode with s[4]=10, s[5]=50: column X0+5 is lit for rows Y0-10 through Y0-50, and column X0+0 lights only row Y0-s[0].
- Write 300 samples in one frame: sample_ready falls after sample 256, samples 257-300 are dropped, and the swap shows samples 0-255.
- Complete a record between two vblnk edges only every other frame: the swap happens on alternate frames, and the displayed record is unchanged in between.
- Assert rst mid-frame with back half full: outputs go to 0, and the trace is absent until the next full record plus swap.
